vm2002_change_dispenser: RTL and testbench
==========================================

// Module: vm2002_change_dispenser
// PURPOSE
//  Downstream of the vm2002 vending FSM: takes the 16-bit change balance (cents) after a sale
//  and pays it out as quarters/dimes/nickels, one coin per hopper handshake. Tracks per-denomination
//  coin inventory, refilled by the supplier. Reports completion, shortfall or hopper timeout.
// PARAMETERS
//  CNT_W        8    width of each coin inventory counter
//  MAX_COINS    200  per-denomination inventory ceiling (refill saturates here)
//  ACK_TIMEOUT  255  cycles coin_valid may wait for coin_ack before abort (8-bit timer)
// PORTS
//  clk           in   1      single clock, rising edge
//  hrst_n        in   1      asynchronous active-low hard reset
//  srst          in   1      synchronous active-high soft reset (abort transaction, keep inventory)
//  bal_valid     in   1      change request valid
//  balance       in   16     change amount in cents, sampled when bal_valid && bal_ready
//  bal_ready     out  1      high only in IDLE
//  coin_valid    out  1      coin request to hopper, registered
//  coin_type     out  2      coin_t: 00 NONE, 01 NICKEL, 10 DIME, 11 QUARTER
//  coin_ack      in   1      hopper dispensed the presented coin
//  refill_valid  in   1      supplier refill strobe
//  refill_type   in   2      coin_t being refilled
//  refill_count  in   4      coins added
//  done          out  1      one-cycle pulse at end of transaction
//  disp_status   out  2      valid with done: 00 OK, 01 SHORT, 10 TIMEOUT
//  residual      out  16     unpaid cents, valid with done
//  q_cnt,d_cnt,n_cnt out CNT_W  current inventory
// BEHAVIOUR
//  Reset (hrst_n low, async): state IDLE, all outputs 0 except bal_ready=1, inventory=0, timer=0.
//  srst: next edge -> IDLE, coin_valid=0, remaining/timer cleared, done not pulsed; inventory kept.
//  States: IDLE, SELECT, ISSUE, FINISH.
//   IDLE: bal_valid -> latch remaining=balance, go SELECT (no done if balance accepted).
//   SELECT (1 cycle, greedy, decided): rem>=25 && q_cnt>0 -> QUARTER; else rem>=10 && d_cnt>0 -> DIME;
//     else rem>=5 && n_cnt>0 -> NICKEL; go ISSUE with coin_valid=1. rem==0 -> FINISH status OK;
//     no coin eligible, rem>0 -> FINISH status SHORT, residual=rem. Non-multiple-of-5 -> SHORT.
//   ISSUE: hold coin_valid/coin_type stable until coin_ack. On ack: rem -= value (25/10/5, never
//     underflows by construction), decrement that inventory, coin_valid=0, timer=0, go SELECT.
//     Timer counts each ISSUE cycle; at ACK_TIMEOUT without ack -> coin_valid=0, FINISH TIMEOUT,
//     residual=rem (unacked coin not deducted). Ack on the expiry cycle wins over timeout.
//   FINISH: done=1 one cycle with disp_status/residual; go IDLE. residual/status hold until next done.
//  Latency: accept at edge 0; first coin_valid after edge 2; min 3 cycles per coin incl. ack cycle.
//  balance==0: done asserted 2 cycles after acceptance, status OK, no coin issued.
//  coin_ack while coin_valid=0: ignored.
//  Refill: honoured only in IDLE (ignored otherwise, no queueing); cnt = min(cnt+refill_count,
//   MAX_COINS); coin_t NONE ignored. Refill and bal_valid same IDLE cycle: both take effect; SELECT
//   sees updated inventory.
//  Arithmetic: rem 16-bit unsigned; inventory add in CNT_W+1 bits before saturation.
// STRUCTURE
//  vm2002_pkg additions: coin_t enum, COIN_VAL_{NICKEL,DIME,QUARTER} constants, disp_state_t,
//   disp_status_t.
//  Sub-module vm2002_coin_bank: three saturating inventory counters, refill + decrement ports,
//   exposes q/d/n counts. FSM, remaining register and ack timer live in top.
// TESTING
//  1 Full inventory, balance=40 -> QUARTER, DIME, NICKEL acked; done, OK, residual=0, q/d/n each -1.
//  2 n_cnt=0, d_cnt=0, balance=30 -> QUARTER only; done, SHORT, residual=5.
//  3 balance=7 -> NICKEL; done, SHORT, residual=2.
//  4 balance=25, never ack -> coin_valid high ACK_TIMEOUT cycles then low; TIMEOUT, residual=25, q_cnt unchanged.
//  5 n_cnt=195, refill NICKEL count=10 in IDLE -> n_cnt=200; same refill during ISSUE -> no change.
//  6 hrst_n low during ISSUE -> coin_valid=0 and counts=0 immediately; srst during ISSUE -> IDLE next
//    edge, no done, inventory preserved; balance=0 -> done 2 cycles later, OK, no coin_valid.

Source files
------------

// File: rtl/vm2002_pkg.sv
// vm2002_pkg: shared types and constants for the vm2002 change dispenser.
// Provides the coin encoding, the dispenser FSM states and the completion status codes,
// plus a helper that maps a coin to its value in cents.
package vm2002_pkg;

  typedef enum logic [1:0] {
    COIN_NONE    = 2'b00,
    COIN_NICKEL  = 2'b01,
    COIN_DIME    = 2'b10,
    COIN_QUARTER = 2'b11
  } coin_t;

  localparam logic [15:0] COIN_VAL_NICKEL  = 16'd5;
  localparam logic [15:0] COIN_VAL_DIME    = 16'd10;
  localparam logic [15:0] COIN_VAL_QUARTER = 16'd25;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SELECT = 2'b01,
    ST_ISSUE  = 2'b10,
    ST_FINISH = 2'b11
  } disp_state_t;

  typedef enum logic [1:0] {
    DS_OK      = 2'b00,
    DS_SHORT   = 2'b01,
    DS_TIMEOUT = 2'b10
  } disp_status_t;

  function automatic logic [15:0] coin_value(input coin_t c);
    logic [15:0] v;
    case (c)
      COIN_QUARTER: v = COIN_VAL_QUARTER;
      COIN_DIME:    v = COIN_VAL_DIME;
      COIN_NICKEL:  v = COIN_VAL_NICKEL;
      default:      v = 16'd0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/vm2002_coin_bank.sv
// vm2002_coin_bank: per-denomination coin inventory (quarters, dimes, nickels).
// Ports: clk_i/hrst_n_i; refill_en_i/refill_type_i/refill_count_i add coins saturating at MAX_COINS;
//        dec_en_i/dec_type_i remove one dispensed coin; q_cnt_o/d_cnt_o/n_cnt_o current counts.
module vm2002_coin_bank
  import vm2002_pkg::*;
#(
  parameter int CNT_W     = 8,
  parameter int MAX_COINS = 200
) (
  input  logic             clk_i,
  input  logic             hrst_n_i,
  input  logic             refill_en_i,
  input  coin_t            refill_type_i,
  input  logic [3:0]       refill_count_i,
  input  logic             dec_en_i,
  input  coin_t            dec_type_i,
  output logic [CNT_W-1:0] q_cnt_o,
  output logic [CNT_W-1:0] d_cnt_o,
  output logic [CNT_W-1:0] n_cnt_o
);

  localparam logic [CNT_W:0]   MAX_W = (CNT_W+1)'(MAX_COINS);
  localparam logic [CNT_W-1:0] ONE   = 1;

  logic [CNT_W-1:0] q_q, d_q, n_q;
  logic [CNT_W-1:0] q_d, d_d, n_d;

  // Sum is formed one bit wider so a near-full counter cannot wrap before clamping.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                               input logic [3:0]       add);
    logic [CNT_W:0] sum;
    logic [CNT_W-1:0] res;
    sum = {1'b0, cnt} + {{(CNT_W-3){1'b0}}, add};
    if (sum > MAX_W) res = MAX_W[CNT_W-1:0];
    else             res = sum[CNT_W-1:0];
    return res;
  endfunction

  always_comb begin
    q_d = q_q;
    d_d = d_q;
    n_d = n_q;
    if (refill_en_i) begin
      case (refill_type_i)
        COIN_QUARTER: q_d = sat_add(q_q, refill_count_i);
        COIN_DIME:    d_d = sat_add(d_q, refill_count_i);
        COIN_NICKEL:  n_d = sat_add(n_q, refill_count_i);
        default:      ;
      endcase
    end
    // Refill and decrement never coincide (refill only in IDLE); zero guard is defensive.
    if (dec_en_i) begin
      case (dec_type_i)
        COIN_QUARTER: if (q_q != '0) q_d = q_q - ONE;
        COIN_DIME:    if (d_q != '0) d_d = d_q - ONE;
        COIN_NICKEL:  if (n_q != '0) n_d = n_q - ONE;
        default:      ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge hrst_n_i) begin
    if (!hrst_n_i) begin
      q_q <= '0;
      d_q <= '0;
      n_q <= '0;
    end else begin
      q_q <= q_d;
      d_q <= d_d;
      n_q <= n_d;
    end
  end

  assign q_cnt_o = q_q;
  assign d_cnt_o = d_q;
  assign n_cnt_o = n_q;

endmodule

// File: rtl/vm2002_change_dispenser.sv
// vm2002_change_dispenser: pays a change balance out as quarters/dimes/nickels, one coin per hopper ack.
// Ports: clk_i/hrst_n_i (async)/srst_i (sync abort); bal_valid_i/balance_i/bal_ready_o request;
//        coin_valid_o/coin_type_o/coin_ack_i hopper; refill_*_i supplier; done_o/disp_status_o/residual_o result; q/d/n_cnt_o.
module vm2002_change_dispenser
  import vm2002_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int MAX_COINS   = 200,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic             clk_i,
  input  logic             hrst_n_i,
  input  logic             srst_i,
  input  logic             bal_valid_i,
  input  logic [15:0]      balance_i,
  output logic             bal_ready_o,
  output logic             coin_valid_o,
  output logic [1:0]       coin_type_o,
  input  logic             coin_ack_i,
  input  logic             refill_valid_i,
  input  logic [1:0]       refill_type_i,
  input  logic [3:0]       refill_count_i,
  output logic             done_o,
  output logic [1:0]       disp_status_o,
  output logic [15:0]      residual_o,
  output logic [CNT_W-1:0] q_cnt_o,
  output logic [CNT_W-1:0] d_cnt_o,
  output logic [CNT_W-1:0] n_cnt_o
);

  localparam logic [7:0] TMR_LAST = 8'(ACK_TIMEOUT - 1);

  disp_state_t  state_q, state_d;
  logic [15:0]  rem_q, rem_d;
  logic [7:0]   timer_q, timer_d;
  coin_t        sel_q, sel_d;
  logic         coin_vld_q, coin_vld_d;
  coin_t        coin_type_q, coin_type_d;
  disp_status_t fin_st_q, fin_st_d;
  logic         done_q, done_d;
  disp_status_t status_q, status_d;
  logic [15:0]  residual_q, residual_d;

  logic             refill_en, dec_en;
  logic [CNT_W-1:0] q_cnt, d_cnt, n_cnt;

  vm2002_coin_bank #(
    .CNT_W     (CNT_W),
    .MAX_COINS (MAX_COINS)
  ) u_bank (
    .clk_i          (clk_i),
    .hrst_n_i       (hrst_n_i),
    .refill_en_i    (refill_en),
    .refill_type_i  (coin_t'(refill_type_i)),
    .refill_count_i (refill_count_i),
    .dec_en_i       (dec_en),
    .dec_type_i     (sel_q),
    .q_cnt_o        (q_cnt),
    .d_cnt_o        (d_cnt),
    .n_cnt_o        (n_cnt)
  );

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    timer_d     = timer_q;
    sel_d       = sel_q;
    coin_vld_d  = coin_vld_q;
    coin_type_d = coin_type_q;
    fin_st_d    = fin_st_q;
    done_d      = 1'b0;
    status_d    = status_q;
    residual_d  = residual_q;
    refill_en   = 1'b0;
    dec_en      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        refill_en = refill_valid_i && (coin_t'(refill_type_i) != COIN_NONE);
        if (bal_valid_i) begin
          rem_d   = balance_i;
          timer_d = '0;
          state_d = ST_SELECT;
        end
      end

      ST_SELECT: begin
        timer_d = '0;
        if (rem_q >= COIN_VAL_QUARTER && q_cnt != '0) begin
          sel_d   = COIN_QUARTER;
          state_d = ST_ISSUE;
        end else if (rem_q >= COIN_VAL_DIME && d_cnt != '0) begin
          sel_d   = COIN_DIME;
          state_d = ST_ISSUE;
        end else if (rem_q >= COIN_VAL_NICKEL && n_cnt != '0) begin
          sel_d   = COIN_NICKEL;
          state_d = ST_ISSUE;
        end else begin
          fin_st_d = (rem_q == '0) ? DS_OK : DS_SHORT;
          state_d  = ST_FINISH;
        end
      end

      ST_ISSUE: begin
        // The hopper request is registered: it rises on the first ISSUE cycle edge,
        // and acks are only meaningful once it is visible.
        if (!coin_vld_q) begin
          coin_vld_d  = 1'b1;
          coin_type_d = sel_q;
        end else if (coin_ack_i) begin
          rem_d       = rem_q - coin_value(sel_q);
          dec_en      = 1'b1;
          coin_vld_d  = 1'b0;
          coin_type_d = COIN_NONE;
          timer_d     = '0;
          state_d     = ST_SELECT;
        end else if (timer_q == TMR_LAST) begin
          coin_vld_d  = 1'b0;
          coin_type_d = COIN_NONE;
          fin_st_d    = DS_TIMEOUT;
          state_d     = ST_FINISH;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end

      ST_FINISH: begin
        done_d     = 1'b1;
        status_d   = fin_st_q;
        residual_d = rem_q;
        state_d    = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    // Soft reset aborts the transaction but leaves inventory and last result alone.
    if (srst_i) begin
      state_d     = ST_IDLE;
      rem_d       = '0;
      timer_d     = '0;
      sel_d       = COIN_NONE;
      coin_vld_d  = 1'b0;
      coin_type_d = COIN_NONE;
      done_d      = 1'b0;
      refill_en   = 1'b0;
      dec_en      = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge hrst_n_i) begin
    if (!hrst_n_i) begin
      state_q     <= ST_IDLE;
      rem_q       <= '0;
      timer_q     <= '0;
      sel_q       <= COIN_NONE;
      coin_vld_q  <= 1'b0;
      coin_type_q <= COIN_NONE;
      fin_st_q    <= DS_OK;
      done_q      <= 1'b0;
      status_q    <= DS_OK;
      residual_q  <= '0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      timer_q     <= timer_d;
      sel_q       <= sel_d;
      coin_vld_q  <= coin_vld_d;
      coin_type_q <= coin_type_d;
      fin_st_q    <= fin_st_d;
      done_q      <= done_d;
      status_q    <= status_d;
      residual_q  <= residual_d;
    end
  end

  assign bal_ready_o   = (state_q == ST_IDLE);
  assign coin_valid_o  = coin_vld_q;
  assign coin_type_o   = coin_type_q;
  assign done_o        = done_q;
  assign disp_status_o = status_q;
  assign residual_o    = residual_q;
  assign q_cnt_o       = q_cnt;
  assign d_cnt_o       = d_cnt;
  assign n_cnt_o       = n_cnt;

endmodule

// File: tb/tb_vm2002_change_dispenser.sv
// tb_vm2002_change_dispenser: directed bench for the change dispenser.
// Expected coins and completion results come from a greedy inventory model and are queued at request time.
// Inputs are driven and outputs sampled 1 time unit after each rising clock edge.
module tb_vm2002_change_dispenser;

  localparam int M_ACK    = 0;
  localparam int M_NOACK  = 1;
  localparam int M_REFILL = 2;
  localparam int M_HRST   = 3;
  localparam int M_SRST   = 4;

  typedef struct packed {
    logic [1:0]  st;
    logic [15:0] res;
  } exp_done_t;

  logic        clk;
  logic        hrst_n, srst;
  logic        bal_valid;
  logic [15:0] balance;
  logic        bal_ready;
  logic        coin_valid;
  logic [1:0]  coin_type;
  logic        coin_ack;
  logic        refill_valid;
  logic [1:0]  refill_type;
  logic [3:0]  refill_count;
  logic        done;
  logic [1:0]  disp_status;
  logic [15:0] residual;
  logic [7:0]  q_cnt, d_cnt, n_cnt;

  int tests = 0;
  int fails = 0;
  int mq = 0, md = 0, mn = 0;

  logic [1:0] coin_q[$];
  exp_done_t  done_q[$];

  vm2002_change_dispenser dut (
    .clk_i          (clk),
    .hrst_n_i       (hrst_n),
    .srst_i         (srst),
    .bal_valid_i    (bal_valid),
    .balance_i      (balance),
    .bal_ready_o    (bal_ready),
    .coin_valid_o   (coin_valid),
    .coin_type_o    (coin_type),
    .coin_ack_i     (coin_ack),
    .refill_valid_i (refill_valid),
    .refill_type_i  (refill_type),
    .refill_count_i (refill_count),
    .done_o         (done),
    .disp_status_o  (disp_status),
    .residual_o     (residual),
    .q_cnt_o        (q_cnt),
    .d_cnt_o        (d_cnt),
    .n_cnt_o        (n_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d fails=%0d", tests, fails);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] pick(input int rem);
    logic [1:0] c;
    c = 2'b00;
    if (rem >= 25 && mq > 0)      c = 2'b11;
    else if (rem >= 10 && md > 0) c = 2'b10;
    else if (rem >= 5 && mn > 0)  c = 2'b01;
    return c;
  endfunction

  task automatic chk_inv(input string tag);
    chk({tag, "_q_cnt"}, {24'd0, q_cnt}, mq);
    chk({tag, "_d_cnt"}, {24'd0, d_cnt}, md);
    chk({tag, "_n_cnt"}, {24'd0, n_cnt}, mn);
  endtask

  task automatic do_refill(input logic [1:0] typ, input logic [3:0] cnt);
    int t;
    refill_valid = 1'b1;
    refill_type  = typ;
    refill_count = cnt;
    tick();
    refill_valid = 1'b0;
    case (typ)
      2'b11: begin t = mq + cnt; mq = (t > 200) ? 200 : t; end
      2'b10: begin t = md + cnt; md = (t > 200) ? 200 : t; end
      2'b01: begin t = mn + cnt; mn = (t > 200) ? 200 : t; end
      default: ;
    endcase
  endtask

  task automatic run_txn(input string tag, input logic [15:0] bal, input int mode);
    int         rem, hi;
    bit         fin, prev, seen;
    logic [1:0] c;
    exp_done_t  de;

    rem = bal;
    if (mode == M_ACK || mode == M_REFILL) begin
      for (int k = 0; k < 64; k++) begin
        c = pick(rem);
        if (c == 2'b00) break;
        coin_q.push_back(c);
        case (c)
          2'b11: begin mq--; rem -= 25; end
          2'b10: begin md--; rem -= 10; end
          default: begin mn--; rem -= 5; end
        endcase
      end
      de.st  = (rem == 0) ? 2'b00 : 2'b01;
      de.res = 16'(rem);
      done_q.push_back(de);
    end else begin
      coin_q.push_back(pick(rem));
      if (mode == M_NOACK) begin
        de.st  = 2'b10;
        de.res = bal;
        done_q.push_back(de);
      end
    end

    bal_valid = 1'b1;
    balance   = bal;
    tick();
    bal_valid = 1'b0;

    fin = 0; prev = 0; hi = 0;
    for (int cyc = 0; cyc < 2000 && !fin; cyc++) begin
      if (coin_valid) hi++;
      if (coin_valid && !prev) begin
        if (coin_q.size() == 0) chk({tag, "_coin_unexpected"}, 1, 0);
        else chk({tag, "_coin_type"}, {30'd0, coin_type}, {30'd0, coin_q.pop_front()});
        case (mode)
          M_ACK: coin_ack = 1'b1;
          M_REFILL: begin
            coin_ack     = 1'b1;
            refill_valid = 1'b1;
            refill_type  = 2'b10;
            refill_count = 4'd10;
          end
          M_HRST: begin
            hrst_n = 1'b0;
            #1;
            chk({tag, "_hrst_coin_valid"}, {31'd0, coin_valid}, 0);
            chk({tag, "_hrst_bal_ready"}, {31'd0, bal_ready}, 1);
            mq = 0; md = 0; mn = 0;
            chk_inv({tag, "_hrst"});
            fin = 1;
          end
          M_SRST: begin
            srst = 1'b1;
            tick();
            srst = 1'b0;
            chk({tag, "_srst_bal_ready"}, {31'd0, bal_ready}, 1);
            chk({tag, "_srst_coin_valid"}, {31'd0, coin_valid}, 0);
            chk({tag, "_srst_done"}, {31'd0, done}, 0);
            fin = 1;
          end
          default: ;
        endcase
      end
      if (done && !fin) begin
        if (done_q.size() == 0) chk({tag, "_done_unexpected"}, 1, 0);
        else begin
          de = done_q.pop_front();
          chk({tag, "_status"}, {30'd0, disp_status}, {30'd0, de.st});
          chk({tag, "_residual"}, {16'd0, residual}, {16'd0, de.res});
        end
        chk({tag, "_coins_left"}, coin_q.size(), 0);
        if (mode == M_NOACK) chk({tag, "_valid_cycles"}, hi, 255);
        fin = 1;
      end
      prev = coin_valid;
      tick();
      coin_ack     = 1'b0;
      refill_valid = 1'b0;
    end
    if (!fin) chk({tag, "_completed_in_budget"}, 0, 1);

    if (mode == M_HRST) begin
      hrst_n = 1'b1;
      tick();
    end
    if (mode == M_SRST) begin
      seen = 0;
      for (int k = 0; k < 6; k++) begin
        if (done || coin_valid) seen = 1;
        tick();
      end
      chk({tag, "_srst_quiet"}, {31'd0, seen}, 0);
    end
    coin_q.delete();
    done_q.delete();
  endtask

  initial begin
    bit cv_seen;
    hrst_n = 1'b0; srst = 1'b0; bal_valid = 1'b0; balance = '0; coin_ack = 1'b0;
    refill_valid = 1'b0; refill_type = 2'b00; refill_count = 4'd0;
    tick();
    tick();
    // Reset state
    chk("rst_bal_ready", {31'd0, bal_ready}, 1);
    chk("rst_coin_valid", {31'd0, coin_valid}, 0);
    chk("rst_coin_type", {30'd0, coin_type}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_status", {30'd0, disp_status}, 0);
    chk("rst_residual", {16'd0, residual}, 0);
    chk_inv("rst");
    hrst_n = 1'b1;
    tick();

    // Full-ish inventory, 40 cents -> Q, D, N, OK
    do_refill(2'b11, 4'd15);
    do_refill(2'b10, 4'd15);
    do_refill(2'b01, 4'd15);
    do_refill(2'b00, 4'd9);
    chk_inv("refill");
    run_txn("t40", 16'd40, M_ACK);
    chk_inv("t40");

    // 7 cents -> one nickel, SHORT residual 2
    run_txn("t7", 16'd7, M_ACK);
    chk_inv("t7");

    // No dimes/nickels: 30 cents -> quarter, SHORT residual 5
    hrst_n = 1'b0;
    tick();
    hrst_n = 1'b1;
    mq = 0; md = 0; mn = 0;
    tick();
    do_refill(2'b11, 4'd2);
    run_txn("t30", 16'd30, M_ACK);
    chk_inv("t30");

    // Hopper never acks -> TIMEOUT, quarter not deducted
    run_txn("tto", 16'd25, M_NOACK);
    chk_inv("tto");

    // Nickel inventory saturates at 200
    for (int k = 0; k < 13; k++) do_refill(2'b01, 4'd15);
    chk({"n195"}, {24'd0, n_cnt}, 195);
    do_refill(2'b01, 4'd10);
    chk({"n_sat"}, {24'd0, n_cnt}, 200);

    // Refill during ISSUE is dropped
    run_txn("trf", 16'd25, M_REFILL);
    chk_inv("trf");

    // Hard reset mid-ISSUE
    run_txn("thr", 16'd5, M_HRST);
    chk_inv("thr_after");

    // Soft reset mid-ISSUE keeps inventory
    do_refill(2'b01, 4'd3);
    run_txn("tsr", 16'd5, M_SRST);
    chk_inv("tsr");

    // Zero balance: done two cycles after acceptance, no coin
    cv_seen   = 0;
    bal_valid = 1'b1;
    balance   = 16'd0;
    tick();
    bal_valid = 1'b0;
    cv_seen |= coin_valid;
    chk("z_done_c1", {31'd0, done}, 0);
    tick();
    cv_seen |= coin_valid;
    chk("z_done_c2", {31'd0, done}, 0);
    tick();
    cv_seen |= coin_valid;
    chk("z_done_c3", {31'd0, done}, 1);
    chk("z_status", {30'd0, disp_status}, 0);
    chk("z_residual", {16'd0, residual}, 0);
    tick();
    chk("z_done_pulse", {31'd0, done}, 0);
    chk("z_no_coin", {31'd0, cv_seen}, 0);
    chk_inv("z");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
